// File: rtl/board_renderer.sv
// board_renderer: pulls the tank/projectile registers and every board cell out
// of game storage, then expands each board cell into a CELL_PX x CELL_PX block
// of pixel plot requests for the VGA draw path. One frame per start pulse.
module board_renderer #(
   parameter int         GRID_W   = 8,
   parameter int         GRID_H   = 8,
   parameter int         CELL_PX  = 4,
   parameter int         READ_LAT = 1,
   parameter logic [2:0] COL_BG   = 3'b000,
   parameter logic [2:0] COL_WALL = 3'b111,
   parameter logic [2:0] COL_T1   = 3'b100,
   parameter logic [2:0] COL_T2   = 3'b001,
   parameter logic [2:0] COL_P1   = 3'b110,
   parameter logic [2:0] COL_P2   = 3'b011
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [3:0] st_mode,
   output logic       st_wren,
   output logic [7:0] st_address,
   input  logic [7:0] st_q,
   output logic [7:0] plot_x,
   output logic [6:0] plot_y,
   output logic [2:0] plot_colour,
   output logic       plot_valid,
   input  logic       plot_ready
);
   localparam int PXW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
   localparam int RCW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
   localparam logic [PXW-1:0] PX_LAST  = PXW'(CELL_PX - 1);
   localparam logic [RCW-1:0] RD_LAST  = RCW'(READ_LAT);
   localparam logic [3:0]     COL_LAST = 4'(GRID_W - 1);
   localparam logic [3:0]     ROW_LAST = 4'(GRID_H - 1);

   typedef enum logic [2:0] {IDLE, REG_RD, CELL_RD, DRAW, DONE} state_t;

   state_t         state;
   logic [RCW-1:0] rd_cnt;
   logic [2:0]     reg_idx;
   logic [3:0]     col, row;
   logic [PXW-1:0] px, py, px_n, py_n;
   logic           bubble;
   logic           last_px;
   logic [7:0]     t1, t1_dir, p1, t2, t2_dir, p2;
   logic [2:0]     cell_colour;
   logic           unused_dirs;

   // Storage is read-only from this block.
   assign st_wren = 1'b0;
   // Direction bytes are captured for completeness but play no part in colour.
   assign unused_dirs = ^{t1_dir, t2_dir};

   function automatic logic [7:0] pix_x(input logic [3:0] c, input logic [PXW-1:0] o);
      return 8'(16'(c) * 16'(CELL_PX) + 16'(o));
   endfunction

   function automatic logic [6:0] pix_y(input logic [3:0] r, input logic [PXW-1:0] o);
      return 7'(16'(r) * 16'(CELL_PX) + 16'(o));
   endfunction

   // Colour of the cell being read: objects override walls, first match wins.
   always_comb begin
      cell_colour = COL_BG;
      if ({col, row} == t1)      cell_colour = COL_T1;
      else if ({col, row} == t2) cell_colour = COL_T2;
      else if ({col, row} == p1) cell_colour = COL_P1;
      else if ({col, row} == p2) cell_colour = COL_P2;
      else if (st_q != 8'd0)     cell_colour = COL_WALL;
   end

   // Next pixel offset inside the cell, x fastest.
   always_comb begin
      last_px = (px == PX_LAST) && (py == PX_LAST);
      px_n    = px + 1'b1;
      py_n    = py;
      if (px == PX_LAST) begin
         px_n = '0;
         py_n = py + 1'b1;
      end
   end

   // Frame sequencer: register reads, then per cell a read, a pixel burst and a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         st_mode     <= 4'd0;
         st_address  <= 8'd0;
         plot_x      <= 8'd0;
         plot_y      <= 7'd0;
         plot_colour <= 3'd0;
         plot_valid  <= 1'b0;
         rd_cnt      <= '0;
         reg_idx     <= 3'd0;
         col         <= 4'd0;
         row         <= 4'd0;
         px          <= '0;
         py          <= '0;
         bubble      <= 1'b0;
         t1          <= 8'd0;
         t1_dir      <= 8'd0;
         p1          <= 8'd0;
         t2          <= 8'd0;
         t2_dir      <= 8'd0;
         p2          <= 8'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state      <= REG_RD;
               busy       <= 1'b1;
               reg_idx    <= 3'd1;
               st_mode    <= 4'd1;
               st_address <= 8'd0;
               rd_cnt     <= '0;
            end
            REG_RD: if (rd_cnt == RD_LAST) begin
               case (reg_idx)
                  3'd1:    t1     <= st_q;
                  3'd2:    t1_dir <= st_q;
                  3'd3:    p1     <= st_q;
                  3'd4:    t2     <= st_q;
                  3'd5:    t2_dir <= st_q;
                  default: p2     <= st_q;
               endcase
               rd_cnt <= '0;
               if (reg_idx == 3'd6) begin
                  state      <= CELL_RD;
                  st_mode    <= 4'd0;
                  st_address <= 8'd0;
                  col        <= 4'd0;
                  row        <= 4'd0;
               end else begin
                  reg_idx <= reg_idx + 3'd1;
                  st_mode <= {1'b0, reg_idx + 3'd1};
               end
            end else begin
               rd_cnt <= rd_cnt + 1'b1;
            end
            CELL_RD: if (rd_cnt == RD_LAST) begin
               rd_cnt      <= '0;
               state       <= DRAW;
               plot_colour <= cell_colour;
               plot_x      <= pix_x(col, '0);
               plot_y      <= pix_y(row, '0);
               px          <= '0;
               py          <= '0;
               plot_valid  <= 1'b1;
               bubble      <= 1'b0;
            end else begin
               rd_cnt <= rd_cnt + 1'b1;
            end
            DRAW: if (bubble) begin
               bubble <= 1'b0;
               if (col == COL_LAST && row == ROW_LAST) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state <= CELL_RD;
                  if (col == COL_LAST) begin
                     col        <= 4'd0;
                     row        <= row + 4'd1;
                     st_address <= {4'd0, row + 4'd1};
                  end else begin
                     col        <= col + 4'd1;
                     st_address <= {col + 4'd1, row};
                  end
               end
            end else if (plot_valid && plot_ready) begin
               if (last_px) begin
                  plot_valid <= 1'b0;
                  bubble     <= 1'b1;
               end else begin
                  px     <= px_n;
                  py     <= py_n;
                  plot_x <= pix_x(col, px_n);
                  plot_y <= pix_y(row, py_n);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: instance 0 (READ_LAT=1) runs all directed
// scenarios, instance 1 (READ_LAT=2) renders one frame alongside the first.
module tb_board_renderer;
   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] start;
   logic [1:0] ready;
   logic       rnd;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   logic [7:0] ram [256];
   logic [7:0] sregs [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string nm, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] stor(input logic [3:0] m, input logic [7:0] a);
      if (m == 4'd0) return ram[a];
      return sregs[m];
   endfunction

   // Colour of board cell (c,r) straight from the priority rule.
   function automatic logic [2:0] exp_col(input int c, input int r);
      logic [7:0] a;
      a = 8'(c * 16 + r);
      if (a == sregs[1]) return 3'b100;
      if (a == sregs[4]) return 3'b001;
      if (a == sregs[3]) return 3'b110;
      if (a == sregs[6]) return 3'b011;
      if (ram[a] != 8'd0) return 3'b111;
      return 3'b000;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gi
      localparam int RL   = g + 1;
      localparam int FLEN = (g == 0) ? 1228 : 1298;
      logic       busy, done, st_wren, plot_valid;
      logic [3:0] st_mode;
      logic [7:0] st_address, plot_x;
      logic [6:0] plot_y;
      logic [2:0] plot_colour;
      logic [7:0] qp [RL];
      logic [17:0] expq [$];
      logic [17:0] e;
      logic [18:0] prev = '0;
      logic [2:0] fb [32][32];
      int xfers = 0, dones = 0, start_cyc = 0;
      bit active = 0, len_chk = 0, stall = 0, busy_d = 0;

      board_renderer #(.READ_LAT(RL)) u_dut (
         .clk(clk), .reset(reset), .start(start[g]), .busy(busy), .done(done),
         .st_mode(st_mode), .st_wren(st_wren), .st_address(st_address),
         .st_q(qp[RL-1]), .plot_x(plot_x), .plot_y(plot_y),
         .plot_colour(plot_colour), .plot_valid(plot_valid), .plot_ready(ready[g]));

      // storage with RL clocks of read latency
      always @(posedge clk) begin
         qp[0] <= stor(st_mode, st_address);
         for (int i = 1; i < RL; i++) qp[i] <= qp[i-1];
      end

      initial forever begin
         @(negedge clk);
         if (reset) begin
            expq.delete();
            active = 0;
            stall  = 0;
            busy_d = 0;
         end else begin
            check(st_wren == 1'b0, "st_wren", longint'(st_wren), 0);
            if (stall)
               check({plot_valid, plot_x, plot_y, plot_colour} == prev, "stall_hold",
                     longint'({plot_valid, plot_x, plot_y, plot_colour}), longint'(prev));
            if (busy && !busy_d) begin
               expq.delete();
               for (int r = 0; r < 8; r++)
                  for (int c = 0; c < 8; c++)
                     for (int py = 0; py < 4; py++)
                        for (int px = 0; px < 4; px++)
                           expq.push_back({8'(c * 4 + px), 7'(r * 4 + py), exp_col(c, r)});
               for (int x = 0; x < 32; x++)
                  for (int y = 0; y < 32; y++) fb[x][y] = 3'b010;
               active    = 1;
               len_chk   = (g == 1) || !rnd;
               start_cyc = cyc;
               xfers     = 0;
            end
            if (active && (cyc - start_cyc) < 6 * (RL + 1))
               check(st_mode == 4'(1 + (cyc - start_cyc) / (RL + 1)) && st_address == 8'd0,
                     "reg_read_seq", longint'({st_mode, st_address}),
                     longint'({4'(1 + (cyc - start_cyc) / (RL + 1)), 8'd0}));
            if (plot_valid && ready[g]) begin
               check(expq.size() > 0, "extra_pixel", longint'({plot_x, plot_y}), 0);
               if (expq.size() > 0) begin
                  e = expq.pop_front();
                  check({plot_x, plot_y, plot_colour} == e, "pixel",
                        longint'({plot_x, plot_y, plot_colour}), longint'(e));
               end
               xfers++;
               if (plot_x < 8'd32 && plot_y < 7'd32) fb[plot_x[4:0]][plot_y[4:0]] = plot_colour;
            end
            if (done) begin
               dones++;
               check(active, "done_unexpected", 1, 0);
               if (len_chk) check(cyc - start_cyc == FLEN, "frame_len", longint'(cyc - start_cyc), FLEN);
               check(expq.size() == 0, "pixels_missing", longint'(expq.size()), 0);
               active = 0;
            end
            stall  = plot_valid && !ready[g];
            prev   = {plot_valid, plot_x, plot_y, plot_colour};
            busy_d = busy;
         end
      end
   end

   // plot_ready: always high, or ~30% high while rnd is set (instance 0 only)
   initial begin
      ready = 2'b11;
      forever begin
         @(posedge clk);
         #1;
         ready[0] = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
         ready[1] = 1'b1;
      end
   end

   task automatic pulse_start(input logic [1:0] m);
      @(posedge clk); #1 start = m;
      @(posedge clk); #1 start = 2'b00;
   endtask

   task automatic wait_dones(input int n0, input int n1, input int lim);
      int k;
      k = 0;
      while ((gi[0].dones < n0 || gi[1].dones < n1) && k < lim) begin
         @(posedge clk);
         k++;
      end
      check(k < lim, "done_timeout", longint'(k), longint'(lim));
   endtask

   initial begin
      int k;
      reset = 1'b1;
      start = 2'b00;
      rnd   = 1'b0;
      for (int i = 0; i < 256; i++) ram[i] = 8'd0;
      for (int i = 0; i < 16; i++) sregs[i] = 8'd0;
      sregs[1] = 8'h21; sregs[2] = 8'h02; sregs[3] = 8'h21;
      sregs[4] = 8'h66; sregs[5] = 8'h03; sregs[6] = 8'h55;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check({gi[0].busy, gi[0].done, gi[0].plot_valid, gi[0].st_wren, gi[0].st_mode,
             gi[0].st_address, gi[0].plot_x, gi[0].plot_y, gi[0].plot_colour} == 34'd0, "reset_state0",
            longint'({gi[0].busy, gi[0].done, gi[0].plot_valid, gi[0].st_wren, gi[0].st_mode,
                      gi[0].st_address, gi[0].plot_x, gi[0].plot_y, gi[0].plot_colour}), 0);
      check({gi[1].busy, gi[1].done, gi[1].plot_valid, gi[1].st_wren, gi[1].st_mode,
             gi[1].st_address, gi[1].plot_x, gi[1].plot_y, gi[1].plot_colour} == 34'd0, "reset_state1",
            longint'({gi[1].busy, gi[1].done, gi[1].plot_valid, gi[1].st_wren, gi[1].st_mode,
                      gi[1].st_address, gi[1].plot_x, gi[1].plot_y, gi[1].plot_colour}), 0);
      @(posedge clk); #1 reset = 1'b0;

      // default frame on both instances, ready always high
      pulse_start(2'b11);
      wait_dones(1, 1, 3000);
      repeat (20) @(posedge clk);
      check(gi[0].dones == 1, "done_once0", longint'(gi[0].dones), 1);
      check(gi[1].dones == 1, "done_once1", longint'(gi[1].dones), 1);
      check(gi[0].xfers == 1024, "xfers0", longint'(gi[0].xfers), 1024);
      check(gi[1].xfers == 1024, "xfers1", longint'(gi[1].xfers), 1024);
      check(gi[0].fb[8][4] == 3'b100, "t1_corner_lo", longint'(gi[0].fb[8][4]), 4);
      check(gi[0].fb[11][7] == 3'b100, "t1_corner_hi", longint'(gi[0].fb[11][7]), 4);
      check(gi[0].fb[25][26] == 3'b001, "t2_pix", longint'(gi[0].fb[25][26]), 1);
      check(gi[0].fb[21][22] == 3'b011, "p2_pix", longint'(gi[0].fb[21][22]), 3);
      check(gi[0].fb[12][4] == 3'b000, "bg_next_to_t1", longint'(gi[0].fb[12][4]), 0);
      check(gi[0].fb[0][0] == 3'b000, "bg_origin", longint'(gi[0].fb[0][0]), 0);
      check(gi[1].fb[9][5] == 3'b100, "lat2_t1_pix", longint'(gi[1].fb[9][5]), 4);
      check(gi[1].fb[24][27] == 3'b001, "lat2_t2_pix", longint'(gi[1].fb[24][27]), 1);

      // wall cell, projectile 2 moved off the grid
      ram[8'h34] = 8'h05;
      sregs[6]   = 8'h93;
      pulse_start(2'b01);
      wait_dones(2, 1, 3000);
      repeat (5) @(posedge clk);
      check(gi[0].fb[12][16] == 3'b111, "wall_lo", longint'(gi[0].fb[12][16]), 7);
      check(gi[0].fb[15][19] == 3'b111, "wall_hi", longint'(gi[0].fb[15][19]), 7);
      check(gi[0].fb[21][22] == 3'b000, "p2_off_grid", longint'(gi[0].fb[21][22]), 0);
      check(gi[0].fb[9][5] == 3'b100, "t1_still", longint'(gi[0].fb[9][5]), 4);

      // random back-pressure
      rnd = 1'b1;
      pulse_start(2'b01);
      wait_dones(3, 1, 20000);
      rnd = 1'b0;
      repeat (5) @(posedge clk);
      check(gi[0].xfers == 1024, "xfers_stalled", longint'(gi[0].xfers), 1024);
      check(gi[0].fb[13][17] == 3'b111, "wall_stalled", longint'(gi[0].fb[13][17]), 7);

      // start pulses while busy and during the done cycle are ignored
      pulse_start(2'b01);
      repeat (5) @(posedge clk);
      pulse_start(2'b01);
      repeat (300) @(posedge clk);
      pulse_start(2'b01);
      k = 0;
      while (!gi[0].done && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      check(k < 3000, "done_wait", longint'(k), 3000);
      start = 2'b01;
      @(posedge clk); #1 start = 2'b00;
      repeat (10) @(posedge clk);
      check(gi[0].dones == 4, "one_done_per_start", longint'(gi[0].dones), 4);
      check(gi[0].busy == 1'b0, "start_in_done_ignored", longint'(gi[0].busy), 0);

      // reset during cell (3,2)
      pulse_start(2'b01);
      k = 0;
      while (!(gi[0].plot_valid && gi[0].plot_x == 8'd12 && gi[0].plot_y == 7'd8) && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      check(k < 3000, "reach_cell_3_2", longint'(k), 3000);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check(gi[0].busy == 1'b0 && gi[0].plot_valid == 1'b0, "abort_state",
            longint'({gi[0].busy, gi[0].plot_valid}), 0);
      repeat (50) @(posedge clk);
      check(gi[0].dones == 4, "no_done_after_reset", longint'(gi[0].dones), 4);
      pulse_start(2'b01);
      wait_dones(5, 1, 3000);
      repeat (5) @(posedge clk);
      check(gi[0].xfers == 1024, "xfers_after_reset", longint'(gi[0].xfers), 1024);
      check(gi[0].fb[0][0] == 3'b000, "origin_after_reset", longint'(gi[0].fb[0][0]), 0);
      check(gi[0].fb[13][17] == 3'b111, "wall_after_reset", longint'(gi[0].fb[13][17]), 7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/board_renderer.md
Name: board_renderer

Overview:
- Read-side initiator for the game storage block. It pulls the six tank/projectile registers and every board RAM cell out of storage, then converts each 8x8 board cell into a CELL_PX x CELL_PX block of pixel plot requests for the VGA draw path.
- It only ever reads storage: st_wren is tied low.
- One frame is rendered per start pulse.

Parameters:
- GRID_W, 8, board columns (max 16)
- GRID_H, 8, board rows (max 16)
- CELL_PX, 4, pixels per cell edge (power of two)
- READ_LAT, 1, storage read latency in clocks (0..3)
- COL_BG, 3'b000, background colour
- COL_WALL, 3'b111, non-zero RAM cell colour
- COL_T1, 3'b100, tank 1 colour
- COL_T2, 3'b001, tank 2 colour
- COL_P1, 3'b110, tank 1 projectile colour
- COL_P2, 3'b011, tank 2 projectile colour

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to render a frame
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last pixel is transferred
- st_mode  out  4  storage mode select (0=RAM, 1..6=registers)
- st_wren  out  1  storage write enable, constant 0
- st_address  out  8  storage address {col[3:0],row[3:0]}
- st_q  in  8  storage read data
- plot_x  out  8  pixel x
- plot_y  out  7  pixel y
- plot_colour  out  3  pixel colour
- plot_valid  out  1  pixel request valid
- plot_ready  in  1  draw path accepts pixel

Behaviour:
- Reset values:
  - busy, done, plot_valid, st_wren = 0.
  - st_mode, st_address, plot_x, plot_y, plot_colour = 0.
  - All captured registers cleared; FSM = IDLE.
- Reset mid-frame aborts immediately to IDLE. No done pulse is produced.
- FSM states: IDLE, REG_RD, CELL_RD, DRAW, DONE.
- IDLE: start=1 moves to REG_RD with reg index 1. start is ignored in every other state.
- Read rule (REG_RD and CELL_RD):
  - st_mode/st_address are driven on the entry cycle and held stable.
  - st_q is captured on the clock edge ending the (READ_LAT+1)th cycle, so each read occupies exactly READ_LAT+1 cycles.
- REG_RD:
  - Reads modes 1..6 in order, st_address=0, into t1, t1_dir, p1, t2, t2_dir, p2.
  - After mode 6, go to CELL_RD with col=0, row=0.
- CELL_RD: st_mode=0, st_address={col,row}. Captures cell value, then goes to DRAW.
- Cell colour, first match wins:
  1. {col,row}==t1 -> COL_T1
  2. ==t2 -> COL_T2
  3. ==p1 -> COL_P1
  4. ==p2 -> COL_P2
  5. cell value!=0 -> COL_WALL
  6. else COL_BG
- Direction registers are captured but not used for colour.
- DRAW:
  - Pixel offsets px, py run from 0 to CELL_PX-1, px fastest.
  - plot_x = col*CELL_PX+px, truncated to 8 bits. plot_y = row*CELL_PX+py, truncated to 7 bits.
  - plot_valid is asserted the cycle DRAW is entered.
  - A transfer occurs on any cycle with plot_valid&plot_ready.
  - While plot_ready=0, x/y/colour/valid are held unchanged.
  - After a transfer the next pixel is presented the following cycle with no bubble. plot_ready is not required to stay high.
- After the last pixel of a cell:
  - Deassert plot_valid for one cycle, then advance the cell.
  - Cells advance row-major: col++; at GRID_W-1, col=0 and row++.
  - If more cells remain -> CELL_RD; after the cell at (GRID_W-1, GRID_H-1) -> DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE. A start in the DONE cycle is ignored.
- Out-of-grid addresses: tank/projectile values with column>=GRID_W or row>=GRID_H simply never match.
- Total per frame with plot_ready=1:
  - 6*(READ_LAT+1) register-read cycles, then per cell (READ_LAT+1) + CELL_PX^2 + 1 cycles.
  - Defaults: 12 + 64*19 = 1228 cycles from the first REG_RD cycle to the DONE cycle.

Test Plan:
- Default parameters, storage model with t1=8'h21, t2=8'h66, p1=8'h21, p2=8'h55, RAM all 0, plot_ready=1:
  - Exactly 1024 transfers.
  - Pixels x 8..11, y 4..7 are 3'b100 (tank 1 beats p1).
  - x 24..27, y 24..27 are 3'b001.
  - x 20..23, y 20..23 are 3'b011.
  - All others are 3'b000.
  - done pulses once, 1228 cycles after the first REG_RD cycle.
- RAM cell 8'h34 = 8'h05, others 0 -> x 12..15, y 16..19 are 3'b111.
- plot_ready random 30% high -> pixel sequence identical to the ready=1 run, outputs stable during stalls, st_wren never 1.
- start pulsed again while busy and in the DONE cycle -> ignored; exactly one done per accepted start.
- reset asserted during DRAW of cell (3,2) -> next cycle busy=0, plot_valid=0, no done; a fresh start then renders a full frame from cell (0,0).
- READ_LAT=2 -> st_mode/st_address held 3 cycles per read, correct capture of every value, frame length 18 + 64*20 = 1298 cycles.
